// File: rtl/alu_packet_engine.sv
// Byte-stream ALU: parses length-framed command packets from UART RX,
// runs echo/add/mul/div and streams result bytes to UART TX.
module alu_packet_engine #(
    parameter int OPERAND_W = 32,
    parameter int LEN_W     = 16
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);
    localparam int W   = OPERAND_W;
    localparam int B   = W / 8;
    localparam int OCW = $clog2(2 * B + 1);
    localparam int BW  = $clog2(B + 1);
    localparam int DW  = $clog2(W);
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    typedef enum logic [2:0] {
        IDLE, HDR, ECHO, OPERAND, DIV, RESULT, DRAIN
    } state_t;

    state_t state, state_n;
    logic [7:0]       opcode, len_lo;
    logic [1:0]       hcnt;
    logic [LEN_W-1:0] left;
    logic [W-1:0]     sh, acc, q, rem, divisor;
    logic [BW-1:0]    bidx;
    logic             second;
    logic [DW-1:0]    dcnt;
    logic [2*W-1:0]   res;
    logic [OCW-1:0]   out_left;
    logic             rdy;

    logic             rx_fire, tx_fire, known, hdr_bad;
    logic [LEN_W-1:0] full_len, pay;
    logic [W-1:0]     word, acc_nxt, rem_n, q_n;
    logic [W:0]       cur;

    assign rx_ready_o = rdy & rst_ni;
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_o && tx_ready_i;
    assign busy_o     = (state != IDLE);

    assign full_len = LEN_W'({rx_data_i, len_lo});
    assign pay      = full_len - LEN_W'(4);
    assign known    = (opcode == OP_ECHO) || (opcode == OP_ADD) ||
                      (opcode == OP_MUL) || (opcode == OP_DIV);
    assign hdr_bad  = !known || (full_len < LEN_W'(4)) ||
                      ((opcode != OP_ECHO) && (pay % LEN_W'(B) != '0)) ||
                      ((opcode == OP_DIV) && (pay != LEN_W'(2 * B)));

    // little-endian operand assembly: new byte enters at the top
    assign word    = (sh >> 8) | (W'(rx_data_i) << (W - 8));
    assign acc_nxt = (opcode == OP_MUL) ? acc * word : acc + word;

    // one restoring-division step
    always_comb begin
        cur = {rem, q[W-1]};
        if (cur >= {1'b0, divisor}) begin
            rem_n = W'(cur - {1'b0, divisor});
            q_n   = {q[W-2:0], 1'b1};
        end else begin
            rem_n = cur[W-1:0];
            q_n   = {q[W-2:0], 1'b0};
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // next state and rx ready
    always_comb begin
        state_n = state;
        rdy     = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (rx_valid_i) state_n = HDR;
            end
            HDR: begin
                rdy = 1'b1;
                if (rx_valid_i && hcnt == 2'd2) begin
                    if (hdr_bad)                     state_n = DRAIN;
                    else if (full_len == LEN_W'(4))
                        state_n = (opcode == OP_ECHO) ? IDLE : RESULT;
                    else if (opcode == OP_ECHO)      state_n = ECHO;
                    else                             state_n = OPERAND;
                end
            end
            ECHO: begin
                rdy = (left != '0) && (!tx_valid_o || tx_ready_i);
                if (left == '0 && (!tx_valid_o || tx_ready_i))
                    state_n = IDLE;
            end
            OPERAND: begin
                rdy = 1'b1;
                if (rx_valid_i && left == LEN_W'(1))
                    state_n = (opcode == OP_DIV) ? DIV : RESULT;
            end
            DIV: begin
                if (divisor == '0 || dcnt == DW'(W - 1)) state_n = RESULT;
            end
            RESULT: begin
                if (tx_fire && out_left == '0) state_n = IDLE;
            end
            DRAIN: begin
                rdy = (left != '0);
                if (left == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath: header capture, operand math, divider and tx byte register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode     <= '0;
            len_lo     <= '0;
            hcnt       <= '0;
            left       <= '0;
            sh         <= '0;
            acc        <= '0;
            q          <= '0;
            rem        <= '0;
            divisor    <= '0;
            bidx       <= '0;
            second     <= 1'b0;
            dcnt       <= '0;
            res        <= '0;
            out_left   <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                IDLE: if (rx_fire) begin
                    opcode <= rx_data_i;
                    hcnt   <= '0;
                end
                HDR: if (rx_fire) begin
                    hcnt <= hcnt + 2'd1;
                    if (hcnt == 2'd1) len_lo <= rx_data_i;
                    if (hcnt == 2'd2) begin
                        left   <= (full_len < LEN_W'(4)) ? '0 : pay;
                        err_o  <= hdr_bad;
                        acc    <= (opcode == OP_MUL) ? W'(1) : '0;
                        bidx   <= '0;
                        second <= 1'b0;
                        res    <= (opcode == OP_MUL) ? (2*W)'(1) : '0;
                        out_left <= OCW'(B);
                    end
                end
                ECHO: begin
                    if (rx_fire) begin
                        tx_data_o  <= rx_data_i;
                        tx_valid_o <= 1'b1;
                        left       <= left - LEN_W'(1);
                    end else if (tx_fire) begin
                        tx_valid_o <= 1'b0;
                    end
                end
                OPERAND: if (rx_fire) begin
                    left <= left - LEN_W'(1);
                    sh   <= word;
                    bidx <= (bidx == BW'(B - 1)) ? '0 : bidx + BW'(1);
                    if (bidx == BW'(B - 1)) begin
                        if (opcode != OP_DIV) begin
                            acc <= acc_nxt;
                        end else if (!second) begin
                            q      <= word;
                            second <= 1'b1;
                        end else begin
                            divisor <= word;
                            rem     <= '0;
                            dcnt    <= '0;
                        end
                    end
                    if (left == LEN_W'(1) && opcode != OP_DIV) begin
                        res      <= {{W{1'b0}}, acc_nxt};
                        out_left <= OCW'(B);
                    end
                end
                DIV: begin
                    if (divisor == '0) begin
                        res      <= {q, {W{1'b1}}};
                        out_left <= OCW'(2 * B);
                    end else begin
                        rem  <= rem_n;
                        q    <= q_n;
                        dcnt <= dcnt + DW'(1);
                        if (dcnt == DW'(W - 1)) begin
                            res      <= {rem_n, q_n};
                            out_left <= OCW'(2 * B);
                        end
                    end
                end
                RESULT: if (!tx_valid_o || tx_fire) begin
                    if (out_left != '0) begin
                        tx_data_o  <= res[7:0];
                        tx_valid_o <= 1'b1;
                        res        <= res >> 8;
                        out_left   <= out_left - OCW'(1);
                    end else begin
                        tx_valid_o <= 1'b0;
                    end
                end
                DRAIN: if (rx_fire) left <= left - LEN_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_packet_engine.sv
// Scoreboard bench for alu_packet_engine: directed spec packets plus
// randomized packets with random rx gaps and tx backpressure.
module tb_alu_packet_engine;
    localparam int W = 32;
    localparam int B = W / 8;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b1;
    logic       busy_o;
    logic       err_o;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int err_exp = 0;
    int rdy_mode = 0;
    bit gaps = 1'b0;
    byte unsigned exp_q[$];
    byte unsigned pl[$];

    alu_packet_engine #(.OPERAND_W(W), .LEN_W(16)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // tx_ready driver: 0 = always ready, 1 = random, 2 = stalled
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      tx_ready_i = 1'b1;
        else if (rdy_mode == 1) tx_ready_i = 1'($urandom_range(0, 1));
        else                    tx_ready_i = 1'b0;
    end

    // monitor: pops expected bytes on each tx handshake, checks stall hold
    initial begin
        bit stall;
        logic [7:0] held;
        byte unsigned e;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    vectors++;
                    if (!tx_valid_o || tx_data_o !== held) begin
                        miscompares++;
                        $display("FAIL tx_hold: got valid=%b data=%h, need valid=1 data=%h",
                                 tx_valid_o, tx_data_o, held);
                    end
                end
                if (tx_valid_o && tx_ready_i) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx_extra: got %h, need no byte", tx_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data_o !== e) begin
                            miscompares++;
                            $display("FAIL tx_byte: got %h, need %h", tx_data_o, e);
                        end
                    end
                end
                stall = tx_valid_o && !tx_ready_i;
                held  = tx_data_o;
                if (err_o) err_seen++;
            end
        end
    end

    function automatic void put_word(input logic [W-1:0] v);
        for (int i = 0; i < B; i++) pl.push_back(byte'(v >> (8 * i)));
    endfunction

    function automatic logic [W-1:0] get_word(input int idx);
        logic [W-1:0] v = '0;
        for (int j = 0; j < B; j++) v |= W'(pl[idx * B + j]) << (8 * j);
        return v;
    endfunction

    function automatic void push_res(input logic [W-1:0] v);
        for (int i = 0; i < B; i++) exp_q.push_back(byte'(v >> (8 * i)));
    endfunction

    // reference model: expected tx bytes / error for one packet
    function automatic void model(input byte unsigned op, input int len);
        int n;
        bit known, bad;
        logic [W-1:0] acc, a, d;
        known = (op == 8'hEC) || (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
        bad = !known || len < 4;
        if (!bad && op != 8'hEC && (len - 4) % B != 0) bad = 1'b1;
        if (!bad && op == 8'hA2 && (len - 4) / B != 2) bad = 1'b1;
        if (bad) begin
            err_exp++;
            return;
        end
        n = (len - 4) / B;
        case (op)
            8'hEC: foreach (pl[i]) exp_q.push_back(pl[i]);
            8'hA0, 8'hA1: begin
                acc = (op == 8'hA1) ? W'(1) : '0;
                for (int i = 0; i < n; i++)
                    acc = (op == 8'hA1) ? acc * get_word(i) : acc + get_word(i);
                push_res(acc);
            end
            default: begin
                a = get_word(0);
                d = get_word(1);
                push_res(d == 0 ? {W{1'b1}} : a / d);
                push_res(d == 0 ? a : a % d);
            end
        endcase
    endfunction

    task automatic send_byte(input byte unsigned b);
        int k;
        bit got;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            got = rx_ready_o;
            @(posedge clk);
            #1;
            k++;
        end while (!got && k < 2000);
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic send_raw(input byte unsigned op, input int len);
        send_byte(op);
        send_byte(byte'($urandom));
        send_byte(byte'(len));
        send_byte(byte'(len >> 8));
        foreach (pl[i]) send_byte(pl[i]);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((busy_o || exp_q.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (k >= 3000) begin
            miscompares++;
            $display("FAIL done_timeout: busy=%b pending=%0d, need 0 and 0",
                     busy_o, exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (err_seen != err_exp) begin
            miscompares++;
            $display("FAIL err_count: got %0d, need %0d", err_seen, err_exp);
            err_seen = err_exp;
        end
    endtask

    task automatic send_pkt(input byte unsigned op, input int len);
        model(op, len);
        send_raw(op, len);
        wait_done();
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if ({rx_ready_o, tx_valid_o, tx_data_o, busy_o, err_o} !== 12'h0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b v=%b d=%h busy=%b err=%b, need all 0",
                     name, rx_ready_o, tx_valid_o, tx_data_o, busy_o, err_o);
        end
    endtask

    task automatic do_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, len, n;
        byte unsigned op;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        do_reset();

        // echo
        pl = '{8'h41, 8'h42, 8'h43};
        send_pkt(8'hEC, 7);
        // add with wrap, then plain add
        pl.delete(); put_word(W'(1)); put_word('1);
        send_pkt(8'hA0, 4 + 2 * B);
        pl.delete(); put_word(W'(5)); put_word(W'(7));
        send_pkt(8'hA0, 4 + 2 * B);
        // mul, div, div by zero
        pl.delete(); put_word(W'(3)); put_word(W'(5));
        send_pkt(8'hA1, 4 + 2 * B);
        pl.delete(); put_word(W'(100)); put_word(W'(7));
        send_pkt(8'hA2, 4 + 2 * B);
        pl.delete(); put_word(W'(100)); put_word('0);
        send_pkt(8'hA2, 4 + 2 * B);
        // empty add / mul
        pl.delete();
        send_pkt(8'hA0, 4);
        send_pkt(8'hA1, 4);
        // malformed packets, then a good one
        pl = '{8'h11, 8'h22};
        send_pkt(8'h55, 6);
        pl.delete(); put_word(W'(9));
        send_pkt(8'hA2, 4 + B);
        pl.delete();
        send_pkt(8'hA0, 2);
        pl.delete(); put_word(W'(40)); put_word(W'(2));
        send_pkt(8'hA0, 4 + 2 * B);

        // long stall mid-result
        rdy_mode = 2;
        pl.delete(); put_word(W'(3)); put_word(W'(5));
        model(8'hA1, 4 + 2 * B);
        send_raw(8'hA1, 4 + 2 * B);
        repeat (50) @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_done();

        // reset during DIV
        pl.delete(); put_word(W'(1000)); put_word(W'(3));
        send_raw(8'hA2, 4 + 2 * B);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (!busy_o) begin
            miscompares++;
            $display("FAIL div_busy: got busy=%b, need 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        check_reset("reset_in_div");
        exp_q.delete();
        do_reset();
        pl.delete(); put_word(W'(1000)); put_word(W'(3));
        send_pkt(8'hA2, 4 + 2 * B);

        // reset during RESULT
        rdy_mode = 2;
        pl.delete(); put_word(W'(12)); put_word(W'(34));
        send_raw(8'hA0, 4 + 2 * B);
        k = 0;
        while (!tx_valid_o && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (!tx_valid_o) begin
            miscompares++;
            $display("FAIL result_valid: got tx_valid=%b, need 1", tx_valid_o);
        end
        rst_ni = 1'b0;
        #1;
        check_reset("reset_in_result");
        rdy_mode = 0;
        exp_q.delete();
        do_reset();
        pl.delete(); put_word(W'(12)); put_word(W'(34));
        send_pkt(8'hA0, 4 + 2 * B);

        // randomized packets with rx gaps and tx backpressure
        for (int t = 0; t < 60; t++) begin
            gaps = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 1);
            pl.delete();
            case ($urandom_range(0, 5))
                0: begin
                    op = 8'hEC;
                    len = 4 + $urandom_range(0, 8);
                    for (int i = 0; i < len - 4; i++) pl.push_back(byte'($urandom));
                end
                1, 2: begin
                    op = 8'hA0 + 8'($urandom_range(0, 1));
                    n = $urandom_range(0, 3);
                    len = 4 + n * B;
                    for (int i = 0; i < n; i++) put_word(W'($urandom));
                end
                3: begin
                    op = 8'hA2;
                    len = 4 + 2 * B;
                    put_word(W'($urandom));
                    put_word($urandom_range(0, 3) == 0 ? '0 : W'($urandom >> $urandom_range(0, 28)));
                end
                4: begin
                    op = 8'($urandom_range(0, 127));
                    len = $urandom_range(0, 9);
                    for (int i = 0; i < len - 4; i++) pl.push_back(byte'($urandom));
                end
                default: begin
                    op = 8'hA0 + 8'($urandom_range(0, 2));
                    len = 4 + B + 1 + ((op == 8'hA2) ? 0 : $urandom_range(0, 1) * B);
                    for (int i = 0; i < len - 4; i++) pl.push_back(byte'($urandom));
                end
            endcase
            send_pkt(op, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
